// File: rtl/bus_arbiter.sv
// Two-master bus front end: non-preemptive grant FSM, request/address/data mux,
// and a one-cycle-delayed read-data return mux steered by the decoder selects.
module bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_dout,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_dout,
    output logic                  m0_grant,
    output logic                  m1_grant,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [DATA_WIDTH-1:0] m_dout,
    input  logic                  s0_sel,
    input  logic                  s1_sel,
    input  logic [DATA_WIDTH-1:0] s0_dout,
    input  logic [DATA_WIDTH-1:0] s1_dout,
    output logic [DATA_WIDTH-1:0] m_din
);

    localparam int unsigned SEL_WIDTH = 2;

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SEL_WIDTH-1:0]   sel_q;

    // Grant state register; reset hands the bus back to master 0 at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= M0_GRANT;
        end else begin
            state <= state_next;
        end
    end

    // Master 0 yields only when idle; master 1 keeps the bus until it drops req.
    always_comb begin
        state_next = state;
        m0_grant   = 1'b1;
        m1_grant   = 1'b0;
        case (state)
            M0_GRANT: begin
                m0_grant = 1'b1;
                m1_grant = 1'b0;
                if (!m0_req && m1_req) begin
                    state_next = M1_GRANT;
                end
            end
            M1_GRANT: begin
                m0_grant = 1'b0;
                m1_grant = 1'b1;
                if (!m1_req) begin
                    state_next = M0_GRANT;
                end
            end
            default: begin
                state_next = M0_GRANT;
            end
        endcase
    end

    // Bus mux driven purely by the grant state.
    always_comb begin
        m_req     = m0_req;
        m_wr      = m0_wr;
        m_address = m0_address;
        m_dout    = m0_dout;
        if (state == M1_GRANT) begin
            m_req     = m1_req;
            m_wr      = m1_wr;
            m_address = m1_address;
            m_dout    = m1_dout;
        end
    end

    // Slave select delayed one cycle to line up with slave read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= SEL_WIDTH'(0);
        end else begin
            sel_q <= {s0_sel, s1_sel};
        end
    end

    // Read-data return; no select or a conflicting double select returns zero.
    always_comb begin
        m_din = DATA_WIDTH'(0);
        case (sel_q)
            2'b10:   m_din = s0_dout;
            2'b01:   m_din = s1_dout;
            default: m_din = DATA_WIDTH'(0);
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a behavioural ownership/read-return model
// checked every cycle, plus literal expectations at key points of the sequence.
module tb_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_address, m1_address, m_address;
    logic [DW-1:0] m0_dout, m1_dout, m_dout;
    logic          m0_grant, m1_grant, m_req, m_wr;
    logic          s0_sel, s1_sel;
    logic [DW-1:0] s0_dout, s1_dout, m_din;

    int vectors = 0;
    int miscompares = 0;
    bit run_model = 1'b0;

    // Model state: who owns the bus, and which slave was selected last cycle.
    int owner;
    int last_slave;

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .m_req(m_req), .m_wr(m_wr), .m_address(m_address), .m_dout(m_dout),
        .s0_sel(s0_sel), .s1_sel(s1_sel), .s0_dout(s0_dout), .s1_dout(s1_dout),
        .m_din(m_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership rules: master 1 takes an idle bus from master 0 and keeps it
    // until it stops requesting. last_slave: -1 none/conflict, 0 or 1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= 0;
            last_slave <= -1;
        end else begin
            if (owner == 0 && m1_req && !m0_req) owner <= 1;
            else if (owner == 1 && !m1_req)      owner <= 0;
            last_slave <= (s0_sel == s1_sel) ? -1 : (s0_sel ? 0 : 1);
        end
    end

    always @(negedge clk) begin
        if (run_model) begin
            check("m0_grant", 64'(m0_grant), 64'(owner == 0));
            check("m1_grant", 64'(m1_grant), 64'(owner == 1));
            check("m_req", 64'(m_req), 64'(owner == 1 ? m1_req : m0_req));
            check("m_wr", 64'(m_wr), 64'(owner == 1 ? m1_wr : m0_wr));
            check("m_address", 64'(m_address), 64'(owner == 1 ? m1_address : m0_address));
            check("m_dout", 64'(m_dout), 64'(owner == 1 ? m1_dout : m0_dout));
            check("m_din", 64'(m_din),
                  64'(last_slave == 0 ? s0_dout : (last_slave == 1 ? s1_dout : '0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r0, r1, sel0, sel1;
    } vec_t;

    vec_t table_v[10];

    initial begin
        reset_n = 1'b0;
        m0_req = 0; m0_wr = 0; m0_address = 16'h1111; m0_dout = 32'hA0A0_0000;
        m1_req = 1; m1_wr = 1; m1_address = 16'h2222; m1_dout = 32'hB1B1_1111;
        s0_sel = 0; s1_sel = 0; s0_dout = 32'hCAFE_0000; s1_dout = 32'hF00D_0001;

        // Reset held with master 1 requesting: master 0 still owns the bus.
        #3;
        check("rst_m0_grant", 64'(m0_grant), 64'd1);
        check("rst_m1_grant", 64'(m1_grant), 64'd0);
        check("rst_m_din", 64'(m_din), 64'd0);
        check("rst_m_address", 64'(m_address), 64'h1111);
        #19 reset_n = 1'b1;
        run_model = 1'b1;
        check("rst_hold_m0", 64'(m0_grant), 64'd1);
        tick();
        check("post_rst_m1_grant", 64'(m1_grant), 64'd1);

        // Handover to master 1 and back.
        m1_address = 16'h7004;
        #1;
        check("ho_m_address", 64'(m_address), 64'h7004);
        check("ho_m_req", 64'(m_req), 64'd1);
        m1_req = 0;
        tick();
        check("ho_back_m0", 64'(m0_grant), 64'd1);

        // Both requesting while master 0 owns: no switch.
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("prio_m0_keeps", 64'(m0_grant), 64'd1);
        end
        m0_req = 0;
        tick();
        check("prio_m1_gets", 64'(m1_grant), 64'd1);
        m0_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("prio_m1_keeps", 64'(m1_grant), 64'd1);
        end
        m1_req = 0;
        tick();
        check("prio_m1_release", 64'(m0_grant), 64'd1);
        m0_req = 0;

        // Read return mux, one cycle after select.
        s0_sel = 1; s0_dout = 32'hDEAD_BEEF;
        tick();
        s0_sel = 0;
        #1;
        check("rd_s0", 64'(m_din), 64'hDEAD_BEEF);
        s1_sel = 1; s1_dout = 32'h1234_5678;
        tick();
        s1_sel = 0;
        check("rd_s1", 64'(m_din), 64'h1234_5678);
        tick();
        check("rd_none", 64'(m_din), 64'd0);
        s0_sel = 1; s1_sel = 1;
        tick();
        s0_sel = 0; s1_sel = 0;
        check("rd_both", 64'(m_din), 64'd0);

        // Master 1 inputs must not leak through while master 0 owns the bus.
        m0_address = 16'hABCD; m0_wr = 0; m1_address = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            m1_wr = ~m1_wr;
            #1;
            check("iso_m_address", 64'(m_address), 64'hABCD);
            check("iso_m_wr", 64'(m_wr), 64'd0);
            tick();
        end

        // Directed request/select table driven through the model.
        table_v[0] = '{0, 1, 1, 0}; table_v[1] = '{1, 1, 0, 1};
        table_v[2] = '{1, 0, 0, 0}; table_v[3] = '{0, 0, 1, 1};
        table_v[4] = '{1, 1, 1, 0}; table_v[5] = '{0, 1, 0, 1};
        table_v[6] = '{0, 1, 0, 0}; table_v[7] = '{1, 0, 1, 0};
        table_v[8] = '{0, 0, 0, 0}; table_v[9] = '{1, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            m0_req = table_v[i].r0; m1_req = table_v[i].r1;
            s0_sel = table_v[i].sel0; s1_sel = table_v[i].sel1;
            m0_dout = 32'h1000 + 32'(i); m1_dout = 32'h2000 + 32'(i);
            s0_dout = 32'h3000 + 32'(i); s1_dout = 32'h4000 + 32'(i);
            tick();
        end

        // Reset in the middle of a master 1 read.
        m0_req = 0; m1_req = 1; s0_sel = 0; s1_sel = 0;
        tick();
        tick();
        check("mr_m1_grant", 64'(m1_grant), 64'd1);
        s1_sel = 1; s1_dout = 32'h55AA_55AA;
        tick();
        s1_sel = 0;
        check("mr_m_din", 64'(m_din), 64'h55AA_55AA);
        #2 reset_n = 1'b0;
        #1;
        check("mr_rst_m0_grant", 64'(m0_grant), 64'd1);
        check("mr_rst_m1_grant", 64'(m1_grant), 64'd0);
        check("mr_rst_m_din", 64'(m_din), 64'd0);
        m1_req = 0;
        #3 reset_n = 1'b1;
        tick();
        tick();

        run_model = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master bus front end that sits directly upstream of the bus address decoder.
- Arbitrates between master 0 and master 1 and muxes the granted master's request, write enable, address and write data onto the shared bus.
- Drives the decoder's grant input (m_req).
- Returns slave read data to the masters through a one-cycle-delayed read-data mux, steered by the decoder's s0_sel/s1_sel.

Parameters:
ADDR_WIDTH, 16, bus address width
DATA_WIDTH, 32, bus data width

Ports:
clk  input  1  bus clock, rising edge
reset_n  input  1  asynchronous active-low reset
m0_req  input  1  master 0 bus request
m0_wr  input  1  master 0 write enable (1=write, 0=read)
m0_address  input  ADDR_WIDTH  master 0 address
m0_dout  input  DATA_WIDTH  master 0 write data
m1_req  input  1  master 1 bus request
m1_wr  input  1  master 1 write enable
m1_address  input  ADDR_WIDTH  master 1 address
m1_dout  input  DATA_WIDTH  master 1 write data
m0_grant  output  1  master 0 owns bus
m1_grant  output  1  master 1 owns bus
m_req  output  1  request of granted master; feeds the decoder's m_grant input
m_wr  output  1  write enable of granted master
m_address  output  ADDR_WIDTH  address of granted master
m_dout  output  DATA_WIDTH  write data of granted master
s0_sel  input  1  slave 0 select from decoder
s1_sel  input  1  slave 1 select from decoder
s0_dout  input  DATA_WIDTH  slave 0 read data (valid one cycle after select)
s1_dout  input  DATA_WIDTH  slave 1 read data (valid one cycle after select)
m_din  output  DATA_WIDTH  read data returned to both masters

Behaviour:
- Clock, reset and grant encoding:
  - One clock domain.
  - reset_n low asynchronously forces state M0_GRANT and the read-select register to 2'b00.
- Reset output values:
  - m0_grant=1, m1_grant=0.
  - m_req, m_wr, m_address, m_dout follow master 0 combinationally.
  - m_din=0.
- FSM, two states, Moore grant outputs:
  - M0_GRANT: m0_grant=1, m1_grant=0.
  - M1_GRANT: m0_grant=0, m1_grant=1.
  - Exactly one grant is high at all times, including during reset.
- Transitions, evaluated on rising clk:
  - M0_GRANT -> M1_GRANT only when m0_req=0 and m1_req=1. Otherwise stay; this includes both requests high and both requests low.
  - M1_GRANT -> M0_GRANT when m1_req=0, regardless of m0_req. Stay while m1_req=1; master 1 is never preempted.
- Grant timing and default owner:
  - A grant change takes effect the cycle after the qualifying request edge. A master must hold its req and see its grant high before its transfer counts.
  - Master 0 is the default owner when idle.
- Bus mux (combinational from state only):
  - m_req/m_wr/m_address/m_dout = granted master's m*_req/m*_wr/m*_address/m*_dout.
  - The non-granted master's inputs have no effect.
- Read-data path:
  - sel_q <= {s0_sel, s1_sel} every rising clk.
  - m_din = s0_dout when sel_q=2'b10; s1_dout when sel_q=2'b01; 0 for 2'b00 and 2'b11.
  - Read latency is one cycle: address presented in cycle N gives data on m_din in cycle N+1.
  - sel_q updates regardless of m_wr; masters ignore m_din on writes.
- Boundary cases:
  - Grant switch in the middle of a read: sel_q still reflects the previous owner's selection for one cycle, so m_din in that cycle belongs to the old transaction. The incoming master must not sample m_din in its first granted cycle.
  - Reset mid-transfer: grant returns to master 0 immediately (asynchronously) and m_din drops to 0 without waiting for clk.
  - Simultaneous m0_req and m1_req rising from idle: master 0 keeps the bus.

Test Plan:
- Reset: hold reset_n=0 with m1_req=1, then release -> m0_grant=1, m1_grant=0, m_din=0 while reset is low; one cycle after release, m1_grant=1.
- Handover: m0_req=0, m1_req=1, m1_address=16'h7004 -> next cycle m1_grant=1, m_address=16'h7004, m_req=1. Then drop m1_req -> next cycle m0_grant=1.
- Priority: both req=1 in M0_GRANT for 5 cycles -> m0_grant stays 1. Switch to M1_GRANT, then assert m0_req=1 with m1_req=1 -> m1_grant stays 1 until m1_req=0.
- Read mux: drive s0_sel=1, s0_dout=32'hDEADBEEF in cycle N -> m_din=32'hDEADBEEF in cycle N+1. Drive s1_sel=1, s1_dout=32'h12345678 -> m_din=32'h12345678 next cycle. Both sels 0 -> m_din=0.
- Mux isolation: master 0 granted, m1_address=16'h0010, m1_wr=1 toggling -> m_address and m_wr track master 0 only.
- Reset mid-read: sel_q=2'b01 and m1_grant=1, assert reset_n=0 between clock edges -> m0_grant=1 and m_din=0 immediately.
